// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM encoding, transfer geometry and
// chip-select decoding.
package spi_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_e;

   localparam int         XFER_BITS = 32;
   localparam logic [3:0] CS_IDLE   = 4'hF;
   localparam logic [5:0] LAST_BIT  = 6'(XFER_BITS - 1);

   // One-hot-low chip select for the addressed target
   function automatic logic [3:0] cs_decode(input logic [1:0] sel);
      cs_decode = ~(4'b0001 << sel);
   endfunction

endpackage

// File: rtl/spi_master_clk_div.sv
// Half-period tick generator for the SPI master; the count restarts whenever
// the enable drops so every transfer begins with a full half-period.
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i || !en_i) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   assign tick_o = en_i && (div_cnt == DIV_LAST);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: 32-bit full-duplex transfer, MSB first, four chip selects,
// started by a rising edge on start_i and reporting completion on done_o.
module spi_master
   import spi_master_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [31:0] data_i,
   input  logic        start_i,
   input  logic [1:0]  sel_i,
   output logic [31:0] data_o,
   output logic        done_o,
   output logic        sclk_o,
   output logic        mosi_o,
   input  logic        miso_i,
   output logic [3:0]  cs_n_o
);

   spi_state_e            state_q, state_d;
   logic                  start_q;
   logic                  start_edge;
   logic                  tick;
   logic                  sclk_q;
   logic [5:0]            bit_cnt;
   logic [1:0]            sel_q;
   logic                  done_q;
   logic [31:0]           data_q;
   logic [XFER_BITS-1:0]  tx_sr;
   logic [XFER_BITS-1:0]  rx_sr;
   logic                  load;
   logic                  sclk_rise;
   logic                  sclk_fall;
   logic                  finish;

   assign start_edge = start_i & ~start_q;

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (state_q != ST_IDLE),
      .tick_o    (tick)
   );

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      finish    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               load    = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tick) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            sclk_rise = tick & ~sclk_q;
            sclk_fall = tick & sclk_q;
            // The last falling edge closes the shift phase instead of shifting
            if (sclk_fall && bit_cnt == LAST_BIT) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (tick) begin
               finish  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         sclk_q  <= 1'b0;
         bit_cnt <= '0;
         sel_q   <= '0;
         done_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_i;
         if (load) begin
            sel_q   <= sel_i;
            done_q  <= 1'b0;
            bit_cnt <= '0;
         end
         if (sclk_rise) sclk_q <= 1'b1;
         if (sclk_fall) begin
            sclk_q <= 1'b0;
            if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 6'd1;
         end
         if (finish) begin
            data_q <= rx_sr;
            done_q <= 1'b1;
         end
      end
   end

   // Shift registers carry no reset: tx is reloaded on every accepted start and
   // rx is completely refilled before it is ever copied to data_o.
   always_ff @(posedge clk_i) begin
      if (load) begin
         tx_sr <= data_i;
      end else if (sclk_fall && bit_cnt != LAST_BIT) begin
         tx_sr <= {tx_sr[XFER_BITS-2:0], 1'b0};
      end
      if (sclk_rise) rx_sr <= {rx_sr[XFER_BITS-2:0], miso_i};
   end

   assign sclk_o = sclk_q;
   assign mosi_o = (state_q != ST_IDLE) && tx_sr[XFER_BITS-1];
   assign cs_n_o = (state_q == ST_IDLE) ? CS_IDLE : cs_decode(sel_q);
   assign done_o = done_q;
   assign data_o = data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        a_start, a_miso, a_done, a_sclk, a_mosi;
   logic [1:0]  a_sel, a_miso_mode;
   logic [31:0] a_data, a_rx;
   logic [3:0]  a_cs_n;

   logic        b_start, b_miso, b_done, b_sclk, b_mosi;
   logic [1:0]  b_sel;
   logic [31:0] b_data, b_rx;
   logic [3:0]  b_cs_n;

   // 0: loopback, 1: tied high, 2: tied low
   always_comb begin
      a_miso = 1'b0;
      case (a_miso_mode)
         2'd0:    a_miso = a_mosi;
         2'd1:    a_miso = 1'b1;
         default: a_miso = 1'b0;
      endcase
   end
   assign b_miso = b_mosi;

   spi_master #(.CLK_DIV(4)) u_a (
      .clk_i(clk), .reset_n_i(rst_n), .data_i(a_data), .start_i(a_start),
      .sel_i(a_sel), .data_o(a_rx), .done_o(a_done), .sclk_o(a_sclk),
      .mosi_o(a_mosi), .miso_i(a_miso), .cs_n_o(a_cs_n)
   );

   spi_master #(.CLK_DIV(1)) u_b (
      .clk_i(clk), .reset_n_i(rst_n), .data_i(b_data), .start_i(b_start),
      .sel_i(b_sel), .data_o(b_rx), .done_o(b_done), .sclk_o(b_sclk),
      .mosi_o(b_mosi), .miso_i(b_miso), .cs_n_o(b_cs_n)
   );

   // Bus monitors, sampled on the falling clock edge
   int          a_rises = 0, b_rises = 0, a_xfers = 0;
   logic [31:0] a_mosi_seq = '0, b_mosi_seq = '0;
   logic [3:0]  a_cs_last = 4'hF, b_cs_last = 4'hF, a_cs_prev = 4'hF;
   logic        a_sclk_prev = 1'b0, b_sclk_prev = 1'b0;

   always @(negedge clk) begin
      if (a_sclk && !a_sclk_prev) begin
         a_rises++;
         a_mosi_seq = {a_mosi_seq[30:0], a_mosi};
         a_cs_last  = a_cs_n;
      end
      if (b_sclk && !b_sclk_prev) begin
         b_rises++;
         b_mosi_seq = {b_mosi_seq[30:0], b_mosi};
         b_cs_last  = b_cs_n;
      end
      if (a_cs_n != 4'hF && a_cs_prev == 4'hF) a_xfers++;
      a_sclk_prev = a_sclk;
      b_sclk_prev = b_sclk;
      a_cs_prev   = a_cs_n;
   end

   int n_checks = 0, n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic get_done(input bit inst);
      return inst ? b_done : a_done;
   endfunction

   // Called at a falling edge; lat is the cycle (relative to the sampling
   // edge N) in which done_o is first seen high, i.e. k+1 for edge N+k.
   task automatic run_xfer(input bit inst, input logic [31:0] data, input logic [1:0] sel,
                           input string tag, output int lat, output logic [3:0] cs_early);
      bit got;
      got      = 1'b0;
      lat      = -1;
      cs_early = 4'hF;
      if (inst) begin b_data = data; b_sel = sel; b_start = 1'b1; end
      else      begin a_data = data; a_sel = sel; a_start = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      if (inst) begin b_start = 1'b0; b_sel = sel ^ 2'b11; end
      else      begin a_start = 1'b0; a_sel = sel ^ 2'b11; end
      check({tag, "_done_drop"}, 32'(get_done(inst)), 32'd0);
      for (int k = 1; k < 3000 && !got; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 2) cs_early = inst ? b_cs_n : a_cs_n;
         if (get_done(inst)) begin
            got = 1'b1;
            lat = k + 1;
         end
      end
      check({tag, "_finished"}, 32'(got), 32'd1);
   endtask

   int          lat, base_r, base_x;
   logic [3:0]  cse;
   bit          seen;

   initial begin
      rst_n = 1'b0;
      a_start = 1'b0; a_sel = 2'd0; a_data = '0; a_miso_mode = 2'd0;
      b_start = 1'b1; b_sel = 2'd1; b_data = 32'h600D_F00D;
      repeat (3) @(negedge clk);

      check("rst_cs_n", 32'(a_cs_n), 32'hF);
      check("rst_sclk", 32'(a_sclk), 32'd0);
      check("rst_mosi", 32'(a_mosi), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_data", a_rx, 32'd0);

      // start_i held high through reset release must start a transfer
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (b_done) seen = 1'b1;
      end
      b_start = 1'b0;
      check("rel_start_done", 32'(seen), 32'd1);
      check("rel_start_data", b_rx, 32'h600D_F00D);

      // Loopback transfer on target 2
      @(negedge clk);
      base_r = a_rises;
      run_xfer(1'b0, 32'hA5C3_0F96, 2'd2, "loop", lat, cse);
      check("loop_latency", 32'(lat), 32'd265);
      check("loop_data", a_rx, 32'hA5C3_0F96);
      check("loop_cs_early", 32'(cse), 32'b1011);
      check("loop_cs_last", 32'(a_cs_last), 32'b1011);
      check("loop_sclk_cnt", 32'(a_rises - base_r), 32'd32);
      check("loop_mosi_seq", a_mosi_seq, 32'hA5C3_0F96);
      check("loop_cs_after", 32'(a_cs_n), 32'hF);
      check("loop_sclk_after", 32'(a_sclk), 32'd0);

      // Constant miso levels
      a_miso_mode = 2'd1;
      run_xfer(1'b0, 32'h1234_5678, 2'd0, "ones", lat, cse);
      check("ones_data", a_rx, 32'hFFFF_FFFF);
      a_miso_mode = 2'd2;
      run_xfer(1'b0, 32'hFFFF_0000, 2'd1, "zeros", lat, cse);
      check("zeros_data", a_rx, 32'h0000_0000);
      check("zeros_latency", 32'(lat), 32'd265);

      // Level held high runs exactly one transfer
      a_miso_mode = 2'd0;
      base_x  = a_xfers;
      a_data  = 32'h0F0F_1234;
      a_sel   = 2'd1;
      a_start = 1'b1;
      repeat (1000) @(negedge clk);
      a_start = 1'b0;
      check("hold_xfers", 32'(a_xfers - base_x), 32'd1);
      check("hold_done", 32'(a_done), 32'd1);
      check("hold_data", a_rx, 32'h0F0F_1234);

      // A second edge mid-transfer is dropped, not queued
      @(negedge clk);
      base_r  = a_rises;
      base_x  = a_xfers;
      a_data  = 32'h8000_0001;
      a_sel   = 2'd3;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (a_rises - base_r >= 10) seen = 1'b1;
      end
      check("mid_reach_bit10", 32'(seen), 32'd1);
      a_data  = 32'hDEAD_BEEF;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (a_done) seen = 1'b1;
      end
      check("mid_finished", 32'(seen), 32'd1);
      check("mid_data", a_rx, 32'h8000_0001);
      check("mid_cs", 32'(a_cs_last), 32'b0111);
      repeat (300) @(negedge clk);
      check("mid_sclk_cnt", 32'(a_rises - base_r), 32'd32);
      check("mid_xfers", 32'(a_xfers - base_x), 32'd1);
      check("mid_done_kept", 32'(a_done), 32'd1);

      // Reset in the middle of a transfer
      base_r  = a_rises;
      a_data  = 32'h5A5A_C3C3;
      a_sel   = 2'd0;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (a_rises - base_r >= 20) seen = 1'b1;
      end
      check("abort_reach_edge20", 32'(seen), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_cs_n", 32'(a_cs_n), 32'hF);
      check("abort_sclk", 32'(a_sclk), 32'd0);
      check("abort_done", 32'(a_done), 32'd0);
      check("abort_data", a_rx, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_xfer(1'b0, 32'h1357_9BDF, 2'd2, "post_rst", lat, cse);
      check("post_rst_data", a_rx, 32'h1357_9BDF);
      check("post_rst_latency", 32'(lat), 32'd265);

      // Fastest divider, then a start edge on the done cycle
      base_r = b_rises;
      run_xfer(1'b1, 32'h3C5A_96E1, 2'd0, "fast", lat, cse);
      check("fast_latency", 32'(lat), 32'd67);
      check("fast_data", b_rx, 32'h3C5A_96E1);
      check("fast_cs", 32'(cse), 32'b1110);
      check("fast_sclk_cnt", 32'(b_rises - base_r), 32'd32);
      check("fast_mosi_seq", b_mosi_seq, 32'h3C5A_96E1);
      run_xfer(1'b1, 32'hC001_D00D, 2'd3, "b2b", lat, cse);
      check("b2b_latency", 32'(lat), 32'd67);
      check("b2b_data", b_rx, 32'hC001_D00D);
      check("b2b_cs_last", 32'(b_cs_last), 32'b0111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
